// File: rtl/regfile_mp.sv
// Multi-port register file with a protected flags register, a busy scoreboard
// and registered read ports. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned FLAG_IDX = 30,
    parameter int unsigned FLAG_W   = 4,
    parameter int unsigned ADDR_W   = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write_enable,
    input  logic [ADDR_W-1:0]         write_addr,
    input  logic [DATA_W-1:0]         write_data,
    input  logic                      setflags,
    input  logic [FLAG_W-1:0]         flags,
    input  logic [NREAD*ADDR_W-1:0]   rd_addr,
    output logic [NREAD*DATA_W-1:0]   rd_data,
    output logic [NREAD-1:0]          rd_busy,
    input  logic                      reserve_en,
    input  logic [ADDR_W-1:0]         reserve_addr,
    output logic [NREGS-1:0]          busy_vec
);

    localparam logic [ADDR_W-1:0] FLAG_A = ADDR_W'(FLAG_IDX);

    // Elaboration-time parameter sanity
    if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
        $error("regfile_mp: NREAD must be 1..4");
    end
    if (NREGS < 4 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("regfile_mp: NREGS must be a power of two >= 4");
    end
    if (FLAG_IDX >= NREGS || FLAG_W > DATA_W) begin : g_bad_flag
        $error("regfile_mp: flags register out of range");
    end

    logic [DATA_W-1:0] store [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic              wr_ok;
    logic [DATA_W-1:0] flags_ext;
    logic [ADDR_W-1:0] rd_addr_a   [NREAD];
    logic [DATA_W-1:0] rd_data_nxt [NREAD];
    logic [NREAD-1:0]  rd_busy_nxt;

    // General writes to the flags register are dropped
    assign wr_ok     = write_enable && (write_addr != FLAG_A);
    assign flags_ext = DATA_W'(flags);
    assign busy_vec  = busy;

    for (genvar gp = 0; gp < NREAD; gp++) begin : g_rd_addr
        assign rd_addr_a[gp] = rd_addr[gp*ADDR_W +: ADDR_W];
    end

    // Scoreboard next state: clears first, reservation last so it wins
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[write_addr] = 1'b0;
        end
        if (setflags) begin
            busy_nxt[FLAG_A] = 1'b0;
        end
        if (reserve_en) begin
            busy_nxt[reserve_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                store[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                store[write_addr] <= write_data;
            end
            if (setflags) begin
                store[FLAG_A] <= flags_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Read mux per port, optionally forwarding the value being written this cycle
    always_comb begin
        for (int p = 0; p < int'(NREAD); p++) begin
            rd_data_nxt[p] = store[rd_addr_a[p]];
            rd_busy_nxt[p] = busy[rd_addr_a[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (write_addr == rd_addr_a[p])) begin
                rd_data_nxt[p] = write_data;
                rd_busy_nxt[p] = busy_nxt[rd_addr_a[p]];
            end else if (setflags && (rd_addr_a[p] == FLAG_A)) begin
                rd_data_nxt[p] = flags_ext;
                rd_busy_nxt[p] = busy_nxt[FLAG_A];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int p = 0; p < int'(NREAD); p++) begin
                rd_data[p*DATA_W +: DATA_W] <= rd_data_nxt[p];
            end
            rd_busy <= rd_busy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_enable;
    logic [4:0]    write_addr;
    logic [63:0]   write_data;
    logic          setflags;
    logic [3:0]    flags;
    logic [9:0]    rd_addr;
    logic [127:0]  rd_data;
    logic [1:0]    rd_busy;
    logic          reserve_en;
    logic [4:0]    reserve_addr;
    logic [31:0]   busy_vec;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [63:0] m_mem [32];
    logic [31:0] m_busy;
    logic [63:0] exp_d [2];
    logic        exp_b [2];

    regfile_mp dut (
        .clk(clk), .rst(rst),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .setflags(setflags), .flags(flags),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .reserve_en(reserve_en), .reserve_addr(reserve_addr),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        write_enable = 1'b0; write_addr = '0; write_data = '0;
        setflags = 1'b0; flags = '0;
        reserve_en = 1'b0; reserve_addr = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_busy = '0;
    endtask

    // Predict read outputs from pre-edge state, apply the edge to the model, advance to next negedge
    task automatic tick();
        logic [4:0] a;
        for (int p = 0; p < 2; p++) begin
            a = rd_addr[p*5 +: 5];
            exp_d[p] = m_mem[a];
            exp_b[p] = m_busy[a];
`ifdef REGFILE_BYPASS_EN
            if (write_enable && write_addr == a && a != 5'd30) begin
                exp_d[p] = write_data;
                exp_b[p] = reserve_en && reserve_addr == a;
            end else if (setflags && a == 5'd30) begin
                exp_d[p] = {60'd0, flags};
                exp_b[p] = reserve_en && reserve_addr == a;
            end
`endif
        end
        if (write_enable && write_addr != 5'd30) begin
            m_mem[write_addr]  = write_data;
            m_busy[write_addr] = 1'b0;
        end
        if (setflags) begin
            m_mem[30]  = {60'd0, flags};
            m_busy[30] = 1'b0;
        end
        if (reserve_en) m_busy[reserve_addr] = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        write_enable = 1'b1; write_addr = 5'd5; write_data = '1;
        reserve_en = 1'b1; reserve_addr = 5'd5;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (rd_data !== '0) begin miscompares++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
            vectors++;
            if (rd_busy !== '0) begin miscompares++; $display("FAIL reset_rd_busy: got %b expected 0", rd_busy); end
            vectors++;
            if (busy_vec !== '0) begin miscompares++; $display("FAIL reset_busy_vec: got %h expected 0", busy_vec); end
        end
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr = {5'(2*i+1), 5'(2*i)};
            tick();
            vectors++;
            if (rd_data !== '0 || rd_busy !== '0) begin
                miscompares++;
                $display("FAIL reset_readall r%0d: got %h/%b expected 0/0", 2*i, rd_data, rd_busy);
            end
            vectors++;
            if (busy_vec !== '0) begin miscompares++; $display("FAIL reset_busy_after: got %h expected 0", busy_vec); end
        end
    endtask

    task automatic test_basic_write();
        idle_inputs();
        write_enable = 1'b1; write_addr = 5'd5; write_data = 64'hDEADBEEF_01234567;
        rd_addr = {5'd0, 5'd0};
        tick();
        idle_inputs();
        rd_addr = {5'd5, 5'd5};
        tick();
        for (int p = 0; p < 2; p++) begin
            vectors++;
            if (rd_data[p*64 +: 64] !== 64'hDEADBEEF_01234567) begin
                miscompares++;
                $display("FAIL basic_write p%0d: got %h expected deadbeef01234567", p, rd_data[p*64 +: 64]);
            end
        end
    endtask

    task automatic test_flags();
        idle_inputs();
        write_enable = 1'b1; write_addr = 5'd30; write_data = 64'hFFFF;
        rd_addr = {5'd0, 5'd0};
        tick();
        idle_inputs();
        rd_addr = {5'd0, 5'd30};
        tick();
        vectors++;
        if (rd_data[63:0] !== 64'h0) begin miscompares++; $display("FAIL flags_protect: got %h expected 0", rd_data[63:0]); end
        setflags = 1'b1; flags = 4'b1010;
        rd_addr = {5'd0, 5'd0};
        tick();
        idle_inputs();
        rd_addr = {5'd0, 5'd30};
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++;
            if (rd_data[63:0] !== 64'hA) begin
                miscompares++;
                $display("FAIL flags_hold c%0d: got %h expected a", c, rd_data[63:0]);
            end
        end
        // General write and flags write in the same cycle, both aimed at the flags register
        write_enable = 1'b1; write_addr = 5'd30; write_data = 64'h1234;
        setflags = 1'b1; flags = 4'b0110;
        rd_addr = {5'd0, 5'd0};
        tick();
        write_enable = 1'b1; write_addr = 5'd12; write_data = 64'hCAFE;
        setflags = 1'b1; flags = 4'b0011;
        tick();
        idle_inputs();
        rd_addr = {5'd12, 5'd30};
        tick();
        vectors++;
        if (rd_data[63:0] !== 64'h3 || rd_data[127:64] !== 64'hCAFE) begin
            miscompares++;
            $display("FAIL flags_dual: got %h/%h expected 3/cafe", rd_data[63:0], rd_data[127:64]);
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        rd_addr = {5'd0, 5'd0};
        reserve_en = 1'b1; reserve_addr = 5'd7;
        tick();
        idle_inputs();
        vectors++;
        if (busy_vec[7] !== 1'b1) begin miscompares++; $display("FAIL sb_reserve: got %b expected 1", busy_vec[7]); end
        rd_addr = {5'd0, 5'd7};
        tick();
        vectors++;
        if (rd_busy[0] !== 1'b1) begin miscompares++; $display("FAIL sb_rd_busy: got %b expected 1", rd_busy[0]); end
        write_enable = 1'b1; write_addr = 5'd7; write_data = 64'h55;
        reserve_en = 1'b1; reserve_addr = 5'd7;
        rd_addr = {5'd0, 5'd0};
        tick();
        idle_inputs();
        vectors++;
        if (busy_vec[7] !== 1'b1) begin miscompares++; $display("FAIL sb_reserve_wins: got %b expected 1", busy_vec[7]); end
        write_enable = 1'b1; write_addr = 5'd7; write_data = 64'h66;
        tick();
        idle_inputs();
        vectors++;
        if (busy_vec[7] !== 1'b0) begin miscompares++; $display("FAIL sb_clear: got %b expected 0", busy_vec[7]); end
        rd_addr = {5'd7, 5'd0};
        tick();
        vectors++;
        if (rd_data[127:64] !== 64'h66 || rd_busy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_read_back: got %h/%b expected 66/0", rd_data[127:64], rd_busy[1]);
        end
    endtask

    task automatic test_same_cycle();
        logic [63:0] want;
        idle_inputs();
        rd_addr = {5'd0, 5'd0};
        write_enable = 1'b1; write_addr = 5'd3; write_data = 64'h99;
        reserve_en = 1'b1; reserve_addr = 5'd3;
        tick();
        idle_inputs();
        write_enable = 1'b1; write_addr = 5'd3; write_data = 64'h1234;
        rd_addr = {5'd3, 5'd3};
        tick();
        idle_inputs();
`ifdef REGFILE_BYPASS_EN
        want = 64'h1234;
        vectors++;
        if (rd_busy !== 2'b00) begin miscompares++; $display("FAIL same_cycle_busy: got %b expected 00", rd_busy); end
`else
        want = 64'h99;
        vectors++;
        if (rd_busy !== 2'b11) begin miscompares++; $display("FAIL same_cycle_busy: got %b expected 11", rd_busy); end
`endif
        vectors++;
        if (rd_data[63:0] !== want || rd_data[127:64] !== want) begin
            miscompares++;
            $display("FAIL same_cycle_data: got %h/%h expected %h", rd_data[63:0], rd_data[127:64], want);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            write_enable = ($urandom_range(0, 3) != 0);
            write_addr   = 5'($urandom_range(0, 31));
            write_data   = {$urandom, $urandom};
            setflags     = ($urandom_range(0, 5) == 0);
            flags        = 4'($urandom);
            reserve_en   = ($urandom_range(0, 2) == 0);
            reserve_addr = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom_range(0, 31));
            for (int p = 0; p < 2; p++) begin
                case ($urandom_range(0, 3))
                    0: rd_addr[p*5 +: 5] = write_addr;
                    1: rd_addr[p*5 +: 5] = 5'd30;
                    default: rd_addr[p*5 +: 5] = 5'($urandom_range(0, 31));
                endcase
            end
            tick();
            for (int p = 0; p < 2; p++) begin
                vectors++;
                if (rd_data[p*64 +: 64] !== exp_d[p] || rd_busy[p] !== exp_b[p]) begin
                    miscompares++;
                    $display("FAIL random c%0d p%0d: got %h/%b expected %h/%b",
                             c, p, rd_data[p*64 +: 64], rd_busy[p], exp_d[p], exp_b[p]);
                end
            end
            vectors++;
            if (busy_vec !== m_busy) begin
                miscompares++;
                $display("FAIL random_busy_vec c%0d: got %h expected %h", c, busy_vec, m_busy);
            end
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        idle_inputs();
        rd_addr = {5'd0, 5'd0};
        write_enable = 1'b1; write_addr = 5'd9; write_data = 64'h42;
        reserve_en = 1'b1; reserve_addr = 5'd9;
        tick();
        idle_inputs();
        rd_addr = {5'd0, 5'd9};
        tick();
        vectors++;
        if (rd_data[63:0] !== 64'h42 || rd_busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_pre: got %h/%b expected 42/1", rd_data[63:0], rd_busy[0]);
        end
        #2;
        write_enable = 1'b1; write_addr = 5'd9; write_data = 64'h77;
        reserve_en = 1'b1; reserve_addr = 5'd9;
        rst = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (rd_data !== '0 || rd_busy !== '0 || busy_vec !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_async: got %h/%b/%h expected 0/0/0", rd_data, rd_busy, busy_vec);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        rd_addr = {5'd9, 5'd9};
        tick();
        vectors++;
        if (rd_data !== '0 || rd_busy !== '0 || busy_vec !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_after: got %h/%b/%h expected 0/0/0", rd_data, rd_busy, busy_vec);
        end
    endtask

    initial begin
        rst = 1'b0;
        rd_addr = '0;
        idle_inputs();
        model_clear();
        test_reset();
        test_basic_write();
        test_flags();
        test_scoreboard();
        test_same_cycle();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the decode stage. It replaces the fixed 32x64 two-read-port file. It adds:
- a configurable number of registered read ports;
- a dedicated flags register written through a separate port;
- a per-register busy scoreboard for in-flight results;
- optional same-cycle write-to-read forwarding.

Decode issues reads and reservations to this block. Writeback drives the write and flags ports.

## Interface
Parameters:
- DATA_W, 64, register width in bits
- NREGS, 32, number of architectural registers (power of two, >= 4)
- NREAD, 2, number of read ports (1..4)
- FLAG_IDX, 30, index of the flags register
- FLAG_W, 4, flag bits stored in the LSBs of register FLAG_IDX
- ADDR_W, $clog2(NREGS), derived register address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- write_enable  in  1  general write strobe
- write_addr  in  ADDR_W  general write address
- write_data  in  DATA_W  general write data
- setflags  in  1  flags write strobe
- flags  in  FLAG_W  new flag value
- rd_addr  in  NREAD*ADDR_W  read addresses, port p at bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
- rd_busy  out  NREAD  registered scoreboard bit of the register read on port p
- reserve_en  in  1  mark a destination register busy
- reserve_addr  in  ADDR_W  register to reserve
- busy_vec  out  NREGS  current scoreboard, one bit per register

## Operation
Storage:
- NREGS x DATA_W.
- Reset clears every register to 0, every busy bit, all of rd_data and rd_busy.

General write:
- When write_enable is high and write_addr != FLAG_IDX, store[write_addr] <= write_data.
- A general write to FLAG_IDX is silently dropped.

Flags write:
- When setflags is high, store[FLAG_IDX] <= zero-extended flags. Upper DATA_W-FLAG_W bits are forced to 0.
- When setflags is low, the flags register holds its value. The previous design rewrote it every cycle; this block does not.

Read ports:
- Every cycle, each port p registers store[rd_addr_p] into rd_data_p and busy[rd_addr_p] into rd_busy_p.
- Reads never stall and have no enable.

Scoreboard:
- A general write that is accepted clears busy[write_addr].
- A flags write clears busy[FLAG_IDX].
- reserve_en sets busy[reserve_addr].
- If a reservation and a clear hit the same register in the same cycle, the reservation wins and the bit ends at 1.
- Reserving an already-busy register leaves it busy.
- busy_vec is the raw scoreboard register.

Simultaneous events:
- write_enable and setflags both high: both complete, on different registers.
- A general write to a register and reads of the same register in that cycle follow the Configuration section.
- Any number of ports may read the same address.

Reset mid-operation:
- Asserting rst asynchronously clears storage, scoreboard and outputs.
- Writes, reservations and reads in flight that cycle are discarded.

## Timing
- Read latency is 1 cycle: an address presented before edge N produces data after edge N.
- Write latency is 1 cycle: data is visible to reads sampled at edge N+1 or later.
- Scoreboard updates at the edge and busy_vec reflects them immediately after that edge.
- rd_busy samples the scoreboard state from before the edge, unless forwarding applies.
- After rst deasserts, the first rising edge performs normal operation.

## Configuration
Macro REGFILE_BYPASS_EN.

When defined, a read sampled in the same cycle as an accepted write to that address returns the new value:
- A general write returns write_data, and rd_busy_p = 0 unless a reservation to that address occurs in the same cycle.
- A flags write to FLAG_IDX returns the zero-extended flags, with the same rd_busy rule.

When undefined:
- The read returns the old stored value.
- rd_busy_p returns the pre-edge busy bit.
- Decode must then insert one bubble after writeback.

## Test plan
- Reset sequence: hold rst=0 for 3 cycles, then read all 32 regs -> every rd_data = 0, busy_vec = 0, and output ports stay 0 while in reset.
- Basic write: write 0xDEADBEEF_01234567 to r5, read r5 on port 0 and r5 on port 1 the next cycle -> both ports show 0xDEADBEEF_01234567 one cycle after the address.
- Flags protection:
  - write 0xFFFF to r30 with write_enable -> r30 remains 0;
  - then setflags=1, flags=4'b1010 -> r30 reads 0x...000A;
  - idle 5 cycles -> still 0xA.
- Scoreboard:
  - reserve r7 -> busy_vec[7]=1 next cycle, and a read of r7 gives rd_busy=1;
  - a cycle with write r7=0x55 plus reserve r7 -> busy stays 1;
  - a later write r7=0x66 -> busy clears and r7 reads 0x66.
- Same-cycle write/read: write r3=0x1234 while port 0 reads r3, with r3 previously 0x99 -> port 0 shows 0x1234 and rd_busy=0 with REGFILE_BYPASS_EN, 0x99 without.
- Reset mid-operation: write r9=0x42, reserve r9, assert rst for 1 cycle mid-clock -> r9 reads 0, busy_vec=0, and rd_data clears asynchronously.
